// File: rtl/stream_arb2.sv
// stream_arb2: two-input round-robin stream arbiter with a single registered output slot
module stream_arb2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ready_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_data_o,
  input  logic             y_ready_i,
  output logic             sel_o
);
  typedef enum logic {PRIO_A, PRIO_B} prio_t;
  prio_t prio, prio_nxt;
  logic space, grant_a, grant_b, a_xfer, b_xfer;
  // priority state register
  always_ff @(posedge clk or posedge reset)
    if (reset) prio <= PRIO_A;
    else prio <= prio_nxt;
  // the channel that just transferred yields priority to the other one
  always_comb begin
    a_xfer = a_valid_i && a_ready_o;
    b_xfer = b_valid_i && b_ready_o;
    prio_nxt = a_xfer ? PRIO_B : b_xfer ? PRIO_A : prio;
  end
  // grant and readies; readies are forced low while reset is held
  always_comb begin
    space = !y_valid_o || y_ready_i;
    grant_a = a_valid_i && (!b_valid_i || prio == PRIO_A);
    grant_b = b_valid_i && (!a_valid_i || prio == PRIO_B);
    a_ready_o = !reset && space && grant_a;
    b_ready_o = !reset && space && grant_b;
  end
  // output slot: load on transfer, clear on drain, otherwise hold
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      y_valid_o <= 1'b0;
      y_data_o <= '0;
      sel_o <= 1'b0;
    end else if (a_xfer || b_xfer) begin
      y_valid_o <= 1'b1;
      y_data_o <= a_xfer ? a_data_i : b_data_i;
      sel_o <= a_xfer;
    end else if (y_ready_i) begin
      y_valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_stream_arb2.sv
// tb_stream_arb2: directed and random checks of stream_arb2 against a reference model and scoreboard
module tb_stream_arb2;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_valid_i = 1'b0, b_valid_i = 1'b0, y_ready_i = 1'b0;
  logic [W-1:0] a_data_i = '0, b_data_i = '0;
  logic a_ready_o, b_ready_o, y_valid_o, sel_o;
  logic [W-1:0] y_data_o;
  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] sb[$];
  logic m_prio, m_yv, m_sel;
  logic [W-1:0] m_yd;

  stream_arb2 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .y_valid_o(y_valid_o), .y_data_o(y_data_o), .y_ready_i(y_ready_i),
    .sel_o(sel_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, check readies mid-cycle, score output, then check registers after the edge
  task automatic cycle(input logic av, input logic [W-1:0] ad, input logic bv,
                       input logic [W-1:0] bd, input logic yr);
    logic sp, ga, gb;
    logic [W:0] e;
    a_valid_i = av; a_data_i = ad; b_valid_i = bv; b_data_i = bd; y_ready_i = yr;
    @(negedge clk);
    sp = !m_yv || yr;
    ga = av && (!bv || !m_prio);
    gb = bv && (!av || m_prio);
    chk("a_ready", a_ready_o, sp && ga);
    chk("b_ready", b_ready_o, sp && gb);
    chk("ready_onehot", a_ready_o && b_ready_o, 0);
    if (y_valid_o === 1'b1 && yr) begin
      chk("sb_underflow", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("y_word", {sel_o, y_data_o}, e);
      end
    end
    if (sp && ga) begin
      sb.push_back({1'b1, ad});
      m_yv = 1'b1; m_yd = ad; m_sel = 1'b1; m_prio = 1'b1;
    end else if (sp && gb) begin
      sb.push_back({1'b0, bd});
      m_yv = 1'b1; m_yd = bd; m_sel = 1'b0; m_prio = 1'b0;
    end else if (yr) begin
      m_yv = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("y_valid", y_valid_o, m_yv);
    chk("y_data", y_data_o, m_yd);
    chk("sel", sel_o, m_sel);
  endtask

  // asynchronous reset pulse between clock edges, with valids pending to prove readies are gated
  task automatic do_reset();
    reset = 1'b1;
    a_valid_i = 1'b1; b_valid_i = 1'b1; y_ready_i = 1'b1;
    #1;
    chk("rst_y_valid", y_valid_o, 0);
    chk("rst_y_data", y_data_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_a_ready", a_ready_o, 0);
    chk("rst_b_ready", b_ready_o, 0);
    #1;
    reset = 1'b0;
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    sb.delete();
    m_prio = 1'b0; m_yv = 1'b0; m_yd = '0; m_sel = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    // single A word
    cycle(1, 8'h5A, 0, 8'h00, 1);
    chk("single_a_data", y_data_o, 8'h5A);
    chk("single_a_sel", sel_o, 1);
    // tie after reset alternates A,B,A,B without gaps
    do_reset();
    cycle(1, 8'h11, 1, 8'h22, 1);
    chk("tie0", {sel_o, y_data_o}, 9'h111);
    cycle(1, 8'h11, 1, 8'h22, 1);
    chk("tie1", {sel_o, y_data_o}, 9'h022);
    cycle(1, 8'h11, 1, 8'h22, 1);
    cycle(1, 8'h11, 1, 8'h22, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    // backpressure: 0x33 held for three stalled cycles, then B loads on the release edge
    cycle(1, 8'h33, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'h55, 1, 8'h66, 0);
    chk("stall_hold", y_data_o, 8'h33);
    cycle(1, 8'h55, 1, 8'h66, 1);
    chk("release_load", {sel_o, y_data_o}, 9'h066);
    cycle(1, 8'h55, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    // drain: one B word, valid for a single cycle, then A wins the next tie
    cycle(0, 8'h00, 1, 8'h44, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    chk("drain_valid", y_valid_o, 0);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(1, 8'h01, 1, 8'h02, 1);
    chk("drain_tie", {sel_o, y_data_o}, 9'h101);
    cycle(0, 8'h00, 0, 8'h00, 1);
    // reset while a word is stalled at the output
    cycle(0, 8'h00, 1, 8'h77, 1);
    cycle(0, 8'h00, 0, 8'h00, 0);
    chk("prestall_data", y_data_o, 8'h77);
    do_reset();
    cycle(1, 8'hA1, 1, 8'hB2, 1);
    chk("post_reset_tie", {sel_o, y_data_o}, 9'h1A1);
    // random stress
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 3) != 0));
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
